// File: rtl/mem_arbiter.sv
// mem_arbiter: shares RAM port A between the CPU memory stage and an external
// requester (program loader / debug DMA). The CPU has priority. The external
// side gets idle slots immediately. An external request that is starved for
// MAX_WAIT cycles forces an ownership period of up to BURST grants. The
// pipeline is stalled for the whole of that period.
//
// Optional feature macro: ARB_BOOT_EN. When it is defined, the reset state is
// BOOT. In BOOT the external side owns the RAM until boot_done is seen.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   mem_req/we/addr/wdata, mem_rdata memory-stage access, load data
//   mem_stall                        the memory-stage access was not performed
//   ext_req/we/addr/wdata            external access request
//   ext_gnt                          transfer = ext_req & ext_gnt (same cycle)
//   ext_rdata, ext_rvalid            read data, valid one cycle after a granted read
//   ram_we_a/addr_a/wdata_a/rdata_a  RAM port A (1-cycle synchronous read)
//   boot_done                        loader finished (BOOT state only)
//   dbg_state, dbg_wait_cnt          FSM state and starvation counter, for observation
//
// Handshake: an external transfer happens in every cycle where ext_req and
// ext_gnt are both high. ext_gnt is combinational, so the requester must hold
// its request and its payload stable until it sees the grant.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_WAIT   = 8,
  parameter int BURST      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic [3:0]            mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_stall,
  input  logic                  ext_req,
  input  logic [3:0]            ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [31:0]           ext_wdata,
  output logic                  ext_gnt,
  output logic [31:0]           ext_rdata,
  output logic                  ext_rvalid,
  output logic [3:0]            ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [31:0]           ram_wdata_a,
  input  logic [31:0]           ram_rdata_a,
  input  logic                  boot_done,
  output logic [1:0]            dbg_state,
  output logic [7:0]            dbg_wait_cnt
);

  typedef enum logic [1:0] {
    SHARE = 2'd0,
    FORCE = 2'd1,
    BOOT  = 2'd2
  } state_t;

`ifdef ARB_BOOT_EN
  localparam state_t RESET_STATE = BOOT;
`else
  // BOOT is unreachable in this build. Its decode is kept so that the
  // next-state logic is the same in both builds.
  localparam state_t RESET_STATE = SHARE;
`endif

  localparam logic [7:0] MAX_W      = 8'(MAX_WAIT);
  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [7:0] burst_cnt, burst_nxt;
  logic       gnt, stall, ext_own;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RESET_STATE;
      wait_cnt   <= 8'd0;
      burst_cnt  <= 8'd0;
      ext_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      burst_cnt  <= burst_nxt;
      ext_rvalid <= ext_req & ext_gnt & (ext_we == 4'b0000);
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    burst_nxt = burst_cnt;
    gnt       = 1'b0;
    stall     = 1'b0;
    ext_own   = 1'b0;
    case (state)
      SHARE: begin
        if (!mem_req && ext_req) begin
          gnt     = 1'b1;
          ext_own = 1'b1;
        end
        if (ext_req && !gnt) begin
          wait_nxt = (wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 8'd1;
          // The CPU still wins the cycle in which the count reaches
          // MAX_WAIT. Forced ownership starts on the next cycle.
          if (wait_nxt == MAX_W) state_nxt = FORCE;
        end else begin
          wait_nxt = 8'd0;
        end
      end
      FORCE: begin
        stall    = 1'b1;
        ext_own  = 1'b1;
        gnt      = ext_req;
        wait_nxt = 8'd0;
        if (ext_req && burst_cnt != BURST_LAST) begin
          burst_nxt = burst_cnt + 8'd1;
        end else begin
          // The burst is used up, or the requester released the RAM early.
          state_nxt = SHARE;
          burst_nxt = 8'd0;
        end
      end
      BOOT: begin
        stall    = 1'b1;
        ext_own  = 1'b1;
        gnt      = ext_req;
        wait_nxt = 8'd0;
        if (boot_done) state_nxt = SHARE;
      end
      default: state_nxt = SHARE;
    endcase
  end

  // Reset gates the grant, the stall and the write strobes combinationally.
  // This stops a write from landing while reset is held, before the state
  // register has settled.
  always_comb begin
    ext_gnt   = gnt & ~reset;
    mem_stall = stall & ~reset;
    if (reset)        ram_we_a = 4'b0000;
    else if (ext_own) ram_we_a = gnt ? ext_we : 4'b0000;
    else              ram_we_a = mem_req ? mem_we : 4'b0000;
    ram_addr_a  = ext_own ? ext_addr  : mem_addr;
    ram_wdata_a = ext_own ? ext_wdata : mem_wdata;
  end

  assign mem_rdata    = ram_rdata_a;
  assign ext_rdata    = ram_rdata_a;
  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

endmodule
